data_memory_responder: RTL and testbench

- Memory-side responder for the address generation unit. It accepts one load/store request per transaction (address, direction, write data) over a valid/ready handshake.
- It drives the synchronous data SRAM with a programmable number of wait states and returns read data or a write acknowledge over a second valid/ready handshake.
- Out-of-range addresses are rejected with an error response and no memory access.

---
 rtl/data_memory_responder.sv | 132 +++++++++++++
 tb/tb_data_memory_responder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// Memory-side responder for the address generation unit.
// Accepts one load/store request at a time, drives a synchronous SRAM with a
// fixed number of wait states and returns read data, a store acknowledge or
// an out-of-range error over a valid/ready response channel.
module data_memory_responder #(
  parameter int          ADDR_W      = 16,
  parameter int          DATA_W      = 16,
  parameter int          WAIT_STATES = 1,
  parameter int unsigned ADDR_LIMIT  = 32'h8000
) (
  input  logic              clk,
  input  logic              a_reset_l,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_wr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_RESP
  } state_t;

  // One extra bit so a limit of 2^ADDR_W (nothing out of range) is representable.
  localparam logic [ADDR_W:0] LIMIT    = (ADDR_W+1)'(ADDR_LIMIT);
  localparam logic [2:0]      WAIT_LD  = 3'(WAIT_STATES);

  state_t     state;
  state_t     state_nxt;
  logic       wr_q;
  logic [2:0] wait_cnt;
  logic       in_range;

  assign in_range = ({1'b0, req_addr} < LIMIT);

  // State register; reset parks the FSM in IDLE, which also drops mem_cs/mem_we.
  always_ff @(posedge clk or negedge a_reset_l) begin
    if (!a_reset_l) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and state-decoded handshake / SRAM strobes.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nxt = in_range ? S_ACCESS : S_RESP;
        end
      end
      S_ACCESS: begin
        mem_cs    = 1'b1;
        mem_we    = wr_q;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt == 3'd0) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request capture, wait counting and response data registers.
  always_ff @(posedge clk or negedge a_reset_l) begin
    if (!a_reset_l) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      wr_q      <= 1'b0;
      wait_cnt  <= 3'd0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            mem_addr  <= req_addr;
            mem_wdata <= req_wdata;
            wr_q      <= req_wr;
            // Rejected requests respond straight away; no SRAM access.
            if (!in_range) begin
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end
          end
        end
        S_ACCESS: begin
          wait_cnt <= WAIT_LD;
        end
        S_WAIT: begin
          if (wait_cnt == 3'd0) begin
            rsp_rdata <= wr_q ? '0 : mem_rdata;
            rsp_err   <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        default: begin
          // RESP holds the response registers until the next transaction.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed testbench for data_memory_responder. Three instances share the
// stimulus bus but have private handshakes and SRAM models:
//   index 0 -> WAIT_STATES=0, index 1 -> WAIT_STATES=1, index 2 -> WAIT_STATES=3.
// Each SRAM model is pre-filled with 16'h1000 + addr[7:0].
module tb_data_memory_responder;

  logic        clk;
  logic        a_reset_l;
  logic [15:0] req_addr;
  logic        req_wr;
  logic [15:0] req_wdata;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [2:0]  rsp_valid;
  logic [2:0]  rsp_ready;
  logic [2:0]  rsp_err;
  logic [2:0]  mem_cs;
  logic [2:0]  mem_we;
  logic [15:0] rsp_rdata [3];
  logic [15:0] mem_addr  [3];
  logic [15:0] mem_wdata [3];
  logic [15:0] mem_rdata [3];

  int nchecks = 0;
  int nerrors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int WS = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    logic [15:0] mem [256];
    logic [15:0] rd;

    initial begin
      for (int j = 0; j < 256; j++) mem[j] <= 16'h1000 + 16'(j);
      rd <= 16'h0;
    end

    // Synchronous SRAM: read data appears the cycle after mem_cs.
    always @(posedge clk) begin
      if (mem_cs[g]) begin
        if (mem_we[g]) mem[mem_addr[g][7:0]] <= mem_wdata[g];
        rd <= mem[mem_addr[g][7:0]];
      end
    end
    assign mem_rdata[g] = rd;

    data_memory_responder #(
      .ADDR_W     (16),
      .DATA_W     (16),
      .WAIT_STATES(WS),
      .ADDR_LIMIT (32'h8000)
    ) u_dut (
      .clk      (clk),
      .a_reset_l(a_reset_l),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_addr (req_addr),
      .req_wr   (req_wr),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_err  (rsp_err[g]),
      .mem_cs   (mem_cs[g]),
      .mem_we   (mem_we[g]),
      .mem_addr (mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction with rsp_ready held high. exp_lat counts rising
  // edges after the accept edge until rsp_valid is seen high (0 = valid in
  // the very cycle following the accept edge, as for an error response).
  task automatic xact(input int i, input logic [15:0] addr, input logic wr,
                      input logic [15:0] wdata, input int exp_lat,
                      input logic exp_err, input logic [15:0] exp_rdata,
                      input string tag);
    int lat;
    int cs_seen;
    int we_seen;
    chk({tag, ".req_ready"}, 32'(req_ready[i]), 32'd1);
    req_addr     = addr;
    req_wr       = wr;
    req_wdata    = wdata;
    req_valid[i] = 1'b1;
    rsp_ready[i] = 1'b1;
    tick();
    req_valid[i] = 1'b0;
    chk({tag, ".mem_addr"}, 32'(mem_addr[i]), 32'(addr));
    chk({tag, ".mem_wdata"}, 32'(mem_wdata[i]), 32'(wdata));
    lat = 0; cs_seen = 0; we_seen = 0;
    while (rsp_valid[i] !== 1'b1 && lat < 20) begin
      cs_seen += int'(mem_cs[i]);
      we_seen += int'(mem_we[i]);
      tick();
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".cs_pulses"}, 32'(cs_seen), exp_err ? 32'd0 : 32'd1);
    chk({tag, ".we_pulses"}, 32'(we_seen), (wr && !exp_err) ? 32'd1 : 32'd0);
    chk({tag, ".rsp_err"}, 32'(rsp_err[i]), 32'(exp_err));
    chk({tag, ".rsp_rdata"}, 32'(rsp_rdata[i]), 32'(exp_rdata));
    tick();
    chk({tag, ".valid_drop"}, 32'(rsp_valid[i]), 32'd0);
    chk({tag, ".ready_back"}, 32'(req_ready[i]), 32'd1);
    chk({tag, ".rdata_hold"}, 32'(rsp_rdata[i]), 32'(exp_rdata));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    a_reset_l = 1'b0;
    req_valid = 3'b000;
    rsp_ready = 3'b000;
    req_addr  = 16'h0;
    req_wr    = 1'b0;
    req_wdata = 16'h0;

    // Test 1: reset for 3 cycles, then release
    repeat (3) tick();
    a_reset_l = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst%0d.mem_cs", i), 32'(mem_cs[i]), 32'd0);
      chk($sformatf("rst%0d.mem_we", i), 32'(mem_we[i]), 32'd0);
      chk($sformatf("rst%0d.rsp_valid", i), 32'(rsp_valid[i]), 32'd0);
      chk($sformatf("rst%0d.rsp_err", i), 32'(rsp_err[i]), 32'd0);
      chk($sformatf("rst%0d.rsp_rdata", i), 32'(rsp_rdata[i]), 32'd0);
      chk($sformatf("rst%0d.mem_addr", i), 32'(mem_addr[i]), 32'd0);
      chk($sformatf("rst%0d.req_ready", i), 32'(req_ready[i]), 32'd1);
    end

    // Test 2: store with WAIT_STATES=1, response 3 edges after accept
    xact(1, 16'h0010, 1'b1, 16'hA5A5, 3, 1'b0, 16'h0000, "st_ws1");

    // Test 3: store then load back with WAIT_STATES=0 and 3; plain load on WS=1
    xact(0, 16'h0010, 1'b1, 16'hA5A5, 2, 1'b0, 16'h0000, "st_ws0");
    xact(0, 16'h0010, 1'b0, 16'h0000, 2, 1'b0, 16'hA5A5, "ld_ws0");
    xact(2, 16'h0010, 1'b1, 16'hA5A5, 5, 1'b0, 16'h0000, "st_ws3");
    xact(2, 16'h0010, 1'b0, 16'h0000, 5, 1'b0, 16'hA5A5, "ld_ws3");
    xact(1, 16'h0022, 1'b0, 16'h0000, 3, 1'b0, 16'h1022, "ld_ws1");

    // Test 4: out-of-range requests, limit boundary, then a legal edge address
    xact(1, 16'hF000, 1'b0, 16'h0000, 0, 1'b1, 16'h0000, "oor_F000");
    xact(1, 16'h7FFF, 1'b0, 16'h0000, 3, 1'b0, 16'h10FF, "ld_7FFF");
    xact(0, 16'h8000, 1'b0, 16'h0000, 0, 1'b1, 16'h0000, "oor_8000");
    xact(0, 16'hFFFF, 1'b1, 16'h1234, 0, 1'b1, 16'h0000, "oor_store");
    xact(0, 16'h00FF, 1'b0, 16'h0000, 2, 1'b0, 16'h10FF, "ld_after_oor");

    // Test 5: backpressure on the WS=1 instance while a new request waits
    req_addr     = 16'h0022;
    req_wr       = 1'b0;
    req_valid[1] = 1'b1;
    rsp_ready[1] = 1'b0;
    tick();
    req_valid[1] = 1'b0;
    lat = 0;
    while (rsp_valid[1] !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    chk("bp.latency", 32'(lat), 32'd3);
    req_addr     = 16'h0010;
    req_valid[1] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("bp%0d.rsp_valid", c), 32'(rsp_valid[1]), 32'd1);
      chk($sformatf("bp%0d.rsp_rdata", c), 32'(rsp_rdata[1]), 32'h1022);
      chk($sformatf("bp%0d.rsp_err", c), 32'(rsp_err[1]), 32'd0);
      chk($sformatf("bp%0d.req_ready", c), 32'(req_ready[1]), 32'd0);
      chk($sformatf("bp%0d.mem_cs", c), 32'(mem_cs[1]), 32'd0);
    end
    rsp_ready[1] = 1'b1;
    tick();
    chk("bp.valid_drop", 32'(rsp_valid[1]), 32'd0);
    chk("bp.req_ready", 32'(req_ready[1]), 32'd1);
    tick();
    req_valid[1] = 1'b0;
    chk("bp.new_cs", 32'(mem_cs[1]), 32'd1);
    chk("bp.new_addr", 32'(mem_addr[1]), 32'h0010);
    lat = 0;
    while (rsp_valid[1] !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    chk("bp.new_latency", 32'(lat), 32'd3);
    chk("bp.new_rdata", 32'(rsp_rdata[1]), 32'hA5A5);
    tick();
    chk("bp.new_done", 32'(rsp_valid[1]), 32'd0);

    // Test 6: reset during WAIT (WAIT_STATES=3, 2 cycles after mem_cs)
    req_addr     = 16'h0022;
    req_wr       = 1'b0;
    req_valid[2] = 1'b1;
    rsp_ready[2] = 1'b1;
    tick();
    req_valid[2] = 1'b0;
    chk("abort.cs", 32'(mem_cs[2]), 32'd1);
    tick();
    tick();
    chk("abort.in_wait", 32'(mem_cs[2] | rsp_valid[2]), 32'd0);
    a_reset_l = 1'b0;
    #1;
    chk("abort.mem_cs", 32'(mem_cs[2]), 32'd0);
    chk("abort.mem_we", 32'(mem_we[2]), 32'd0);
    chk("abort.rsp_valid", 32'(rsp_valid[2]), 32'd0);
    chk("abort.rsp_err", 32'(rsp_err[2]), 32'd0);
    chk("abort.rsp_rdata", 32'(rsp_rdata[2]), 32'd0);
    chk("abort.mem_addr", 32'(mem_addr[2]), 32'd0);
    chk("abort.mem_wdata", 32'(mem_wdata[2]), 32'd0);
    chk("abort.req_ready", 32'(req_ready[2]), 32'd1);
    tick();
    a_reset_l = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      seen += int'(rsp_valid[2]) + int'(mem_cs[2]);
    end
    chk("abort.no_response", 32'(seen), 32'd0);
    chk("abort.ready_after", 32'(req_ready[2]), 32'd1);
    xact(2, 16'h0010, 1'b0, 16'h0000, 5, 1'b0, 16'hA5A5, "ld_after_abort");

    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end

endmodule
